systolic_result_collector: RTL and testbench
============================================

# systolic_result_collector

Receiving end of the systolic array frame's result path. Samples the column-skewed `result_out` stream leaving the bottom of the array, deskews it into whole rows, and buffers one full MATRIX_SIZE×MATRIX_SIZE result tile. It then drains the tile row by row to a downstream consumer over a valid/ready handshake. It drives the frame's `output_ready`, so a new tile is accepted only once the previous one has fully drained.

## Interface
Parameters:
- MATRIX_SIZE, 2, array dimension N (rows per tile = columns = N); N ≥ 2
- DATA_SIZE, 32, width of one result element

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- result_in  input  [DATA_SIZE-1:0] x N  per-column result lanes from the frame
- result_start  input  1  one-cycle pulse: column 0 of row 0 is valid on result_in this cycle
- output_ready  output  1  to frame: collector is empty and can take a tile
- out_valid  output  1  out_row / out_index valid
- out_ready  input  1  consumer accepts the current row
- out_row  output  [DATA_SIZE-1:0] x N  one deskewed result row, element j = column j
- out_index  output  $clog2(N) (min 1)  row number of out_row
- done  output  1  one-cycle pulse after the last row transfers
- overrun  output  1  sticky: result_start seen while not IDLE

## Operation
- Skew contract: with result_start sampled at edge T, element (r, j) is valid on result_in[j] at edge T + r + j, for r, j in 0..N-1.
- Deskew: lane j is delayed by N-1-j registers, so row r emerges aligned at edge T + r + N-1.
- FSM states:
  - IDLE: output_ready=1. result_start → CAPTURE; deskew chain begins shifting.
  - CAPTURE: a row counter counts 0..N-1 from the first aligned row. Each aligned row is written into buffer[row]. After row N-1 is written → DRAIN.
  - DRAIN: out_valid=1, out_row=buffer[rd_ptr], out_index=rd_ptr.
    - On out_valid & out_ready: rd_ptr++.
    - On the transfer of row N-1: done pulses for one cycle, rd_ptr wraps to 0, state → IDLE.
- The deskew chain shifts every cycle in CAPTURE regardless of lane content; data is pass-through only, with no arithmetic.
- result_start in CAPTURE or DRAIN: ignored (no restart, buffer untouched); overrun is set to 1 and held until reset.
- out_ready held low in DRAIN: out_row and out_index stay stable; no timeout.
- Reset mid-CAPTURE or mid-DRAIN: buffer contents are discarded, the FSM is forced to IDLE, and no done pulse is issued.

## Timing
- Reset values: state IDLE, output_ready 1, out_valid 0, out_row all 0, out_index 0, done 0, overrun 0, counters 0.
- output_ready is decoded from state only; it falls the cycle after result_start is sampled.
- Last element (N-1, N-1) is sampled at T + 2N-2. out_valid rises at T + 2N-1 (latency 2N-1 cycles from result_start).
- With out_ready held high, the drain takes N cycles. done is asserted in the cycle after the final transfer, and output_ready returns in that same cycle.
- Back-to-back throughput: minimum 3N-1 cycles per tile; the next result_start is legal in the first cycle output_ready=1.
- out_valid must not depend combinationally on out_ready.

## Structure
- Shared package systolic_pkg:
  - `collector_state_t` enum {IDLE, CAPTURE, DRAIN}
  - index width function `$clog2(N)` clamped to ≥1
  - reused by the frame and other bench components
- Sub-module output_deskewer (parameters MATRIX_SIZE, DATA_SIZE; ports clk, reset, shift_en, lanes_in, row_out): a triangular register chain, the mirror of the frame's input skewer. The FSM, buffer and drain logic live in the top.

## Test plan
- N=2, result_start at T. Drive lane0 = 1 @T, 3 @T+1; lane1 = 2 @T+1, 4 @T+2. → out_valid at T+3 with out_index 0, out_row {1,2}; next cycle out_index 1, out_row {3,4}; done one cycle later; output_ready back to 1.
- N=2, out_ready low for 5 cycles in DRAIN → out_row {1,2} and out_index 0 stable throughout, no done; release → normal drain.
- result_start pulsed during CAPTURE and again during DRAIN → buffer unchanged, output rows still correct, overrun=1 until reset.
- Reset asserted during DRAIN after row 0 transfers → all outputs at reset values immediately, output_ready=1, no done. A new tile afterward drains correctly from row 0.
- N=4, back-to-back tiles with out_ready=1, elements (r,j) = 16·r + j → rows 0..3 exact. Second result_start accepted exactly 11 cycles after the first.
- Reset held low at power-up, then released → output_ready=1, out_valid=0, overrun=0 on the first post-reset edge.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array frame and its collector.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } collector_state_t;

  // Index width for an N-entry structure, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_deskewer.sv
// Triangular delay chain that realigns column-skewed result lanes into rows.
// Latency: lane j delayed N-1-j shift cycles; lane N-1 is combinational pass-through.
// Backpressure: none; advances only when shift_en is high.
module output_deskewer #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  shift_en,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] lanes_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_out
);

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
    localparam int DEPTH = MATRIX_SIZE - 1 - j;
    if (DEPTH == 0) begin : g_thru
      assign row_out[j] = lanes_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (shift_en) begin
          stage[0] <= lanes_in[j];
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign row_out[j] = stage[DEPTH-1];
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Deskews the array's result stream, buffers one NxN tile, drains it row by row.
// Latency: out_valid 2N-1 cycles after result_start; N-cycle drain at full rate.
// Backpressure: out_ready low holds the current row; output_ready low until drained.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  result_in,
  input  logic                                   result_start,
  output logic                                   output_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  out_row,
  output logic [idx_width(MATRIX_SIZE)-1:0]      out_index,
  output logic                                   done,
  output logic                                   overrun
);

  localparam int IDX_W = idx_width(MATRIX_SIZE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MATRIX_SIZE - 1);

  collector_state_t state;
  logic [IDX_W-1:0] skew_cnt;
  logic [IDX_W-1:0] wr_row;
  logic [IDX_W-1:0] rd_ptr;
  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] buffer;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned_row;
  logic shift_en;
  logic aligned;

  // The start cycle itself must shift so row 0's early lanes enter the chain.
  assign shift_en = (state == CAPTURE) || ((state == IDLE) && result_start);
  assign aligned  = (skew_cnt == LAST);

  output_deskewer #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .DATA_SIZE   (DATA_SIZE)
  ) u_deskew (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .lanes_in (result_in),
    .row_out  (aligned_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skew_cnt <= '0;
      wr_row   <= '0;
      rd_ptr   <= '0;
      buffer   <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (result_start && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (result_start) begin
            state    <= CAPTURE;
            skew_cnt <= IDX_W'(1);
            wr_row   <= '0;
          end
        end
        CAPTURE: begin
          // skew_cnt saturates at N-1: from then on each cycle delivers one whole row
          if (!aligned) begin
            skew_cnt <= skew_cnt + IDX_W'(1);
          end else begin
            buffer[wr_row] <= aligned_row;
            if (wr_row == LAST) begin
              state    <= DRAIN;
              wr_row   <= '0;
              skew_cnt <= '0;
            end else begin
              wr_row <= wr_row + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST) begin
              rd_ptr <= '0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign output_ready = (state == IDLE);
  assign out_valid    = (state == DRAIN);
  assign out_index    = rd_ptr;
  assign out_row      = out_valid ? buffer[rd_ptr] : '0;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench: N=2 instance driven from a vector table and reset sequences; N=4 instance
// driven with random tiles and checked against a tile-level scoreboard.
module tb_systolic_result_collector;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=2 instance
  logic              start2, rdy2, ordy2, vld2, done2, ovr2;
  logic [1:0][31:0]  lanes2, row2;
  logic [0:0]        idx2;

  systolic_result_collector #(.MATRIX_SIZE(2), .DATA_SIZE(32)) u_dut2 (
    .clk(clk), .reset(rst_n), .result_in(lanes2), .result_start(start2),
    .output_ready(ordy2), .out_valid(vld2), .out_ready(rdy2), .out_row(row2),
    .out_index(idx2), .done(done2), .overrun(ovr2));

  // N=4 instance
  logic              start4, rdy4, ordy4, vld4, done4, ovr4;
  logic [3:0][31:0]  lanes4, row4;
  logic [1:0]        idx4;

  systolic_result_collector #(.MATRIX_SIZE(4), .DATA_SIZE(32)) u_dut4 (
    .clk(clk), .reset(rst_n), .result_in(lanes4), .result_start(start4),
    .output_ready(ordy4), .out_valid(vld4), .out_ready(rdy4), .out_row(row4),
    .out_index(idx4), .done(done4), .overrun(ovr4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- N=2 vector table ----------------
  typedef struct {
    int st, l0, l1, rdy;                 // inputs for the coming edge
    int vld, idx, r0, r1, dn, ordy, ovr; // outputs after that edge
  } vec_t;

  function automatic vec_t mk(int st, int l0, int l1, int rdy, int vld, int idx,
                              int r0, int r1, int dn, int ordy, int ovr);
    vec_t v;
    v.st = st; v.l0 = l0; v.l1 = l1; v.rdy = rdy;
    v.vld = vld; v.idx = idx; v.r0 = r0; v.r1 = r1; v.dn = dn; v.ordy = ordy; v.ovr = ovr;
    return v;
  endfunction

  task automatic apply2(input int st, input int l0, input int l1, input int rdy);
    start2    = (st != 0);
    lanes2[0] = 32'(l0);
    lanes2[1] = 32'(l1);
    rdy2      = (rdy != 0);
  endtask

  task automatic expect2(input int vld, input int idx, input int r0, input int r1,
                         input int dn, input int ordy, input int ovr);
    chk("n2_out_valid",    int'(vld2),    vld);
    chk("n2_out_index",    int'(idx2),    idx);
    chk("n2_out_row0",     int'(row2[0]), r0);
    chk("n2_out_row1",     int'(row2[1]), r1);
    chk("n2_done",         int'(done2),   dn);
    chk("n2_output_ready", int'(ordy2),   ordy);
    chk("n2_overrun",      int'(ovr2),    ovr);
  endtask

  // ---------------- N=4 scoreboard ----------------
  typedef logic [3:0][31:0] row4_t;
  row4_t exp_rows[$];
  int    start_edges[$];

  task automatic drive_tile4(input bit fixed);
    int w;
    logic [31:0] tile [4][4];
    w = 0;
    while (ordy4 !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL n4_wait_output_ready: got timeout expected output_ready=1");
      return;
    end
    for (int r = 0; r < 4; r++) begin
      row4_t rw;
      for (int j = 0; j < 4; j++) begin
        tile[r][j] = fixed ? 32'(16 * r + j) : $urandom;
        rw[j] = tile[r][j];
      end
      exp_rows.push_back(rw);
    end
    start_edges.push_back(cyc + 1);
    // Element (r,j) must be on lane j at start edge + r + j; anything else is noise.
    for (int k = 0; k < 7; k++) begin
      start4 = (k == 0);
      for (int j = 0; j < 4; j++) begin
        if (k - j >= 0 && k - j < 4) lanes4[j] = tile[k-j][j];
        else                         lanes4[j] = $urandom;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
  endtask

  task automatic monitor4(input int ntiles, input bit rand_rdy);
    int got, tile, ptr, guard;
    bit seen, dpend, rdy;
    got = 0; tile = 0; ptr = 0; guard = 0; seen = 0; dpend = 0;
    while (got < ntiles * 4 && guard < 3000) begin
      @(negedge clk);
      guard++;
      chk("n4_done", int'(done4), int'(dpend));
      dpend = 0;
      rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (vld4) begin
        if (exp_rows.size() == 0 || start_edges.size() <= tile) begin
          checks++; errors++;
          $display("FAIL n4_spurious_valid: got out_valid=1 expected 0");
        end else begin
          if (!seen) begin
            seen = 1;
            chk("n4_latency", cyc + 1 - start_edges[tile], 7);
          end
          chk("n4_out_index", int'(idx4), ptr);
          for (int j = 0; j < 4; j++) chk("n4_out_row", int'(row4[j]), int'(exp_rows[0][j]));
          if (rdy) begin
            void'(exp_rows.pop_front());
            got++;
            ptr++;
            if (ptr == 4) begin
              ptr = 0; tile++; seen = 0; dpend = 1;
            end
          end
        end
      end
      rdy4 = rdy;
    end
    if (guard >= 3000) begin
      checks++; errors++;
      $display("FAIL n4_drain_timeout: got %0d rows expected %0d", got, ntiles * 4);
    end
    if (dpend) begin
      @(negedge clk);
      chk("n4_done_last", int'(done4), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];

  initial begin
    rst_n  = 1'b0;
    apply2(0, 0, 0, 0);
    start4 = 1'b0;
    rdy4   = 1'b1;
    lanes4 = '0;

    // Power-up reset, released away from the clock edge.
    repeat (3) @(negedge clk);
    chk("por_in_reset_output_ready", int'(ordy2), 1);
    rst_n = 1'b1;
    @(negedge clk);
    expect2(0, 0, 0, 0, 0, 1, 0);
    chk("por_n4_output_ready", int'(ordy4), 1);
    chk("por_n4_out_valid",    int'(vld4),  0);
    chk("por_n4_overrun",      int'(ovr4),  0);

    // Basic tile, stalled drain, and result_start during CAPTURE/DRAIN.
    tbl.push_back(mk(1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 2, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4, 1,  1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 1, 3, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0));

    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 2, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0,  1, 0, 1, 2, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0,  1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 1, 3, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0));

    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 2, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4, 0,  1, 0, 1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 9, 9, 0,  1, 0, 1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1,  1, 1, 3, 4, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1));

    foreach (tbl[i]) begin
      apply2(tbl[i].st, tbl[i].l0, tbl[i].l1, tbl[i].rdy);
      @(negedge clk);
      expect2(tbl[i].vld, tbl[i].idx, tbl[i].r0, tbl[i].r1, tbl[i].dn, tbl[i].ordy, tbl[i].ovr);
    end

    // Reset clears the sticky overrun.
    rst_n = 1'b0;
    #1;
    chk("ovr_cleared_by_reset", int'(ovr2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect2(0, 0, 0, 0, 0, 1, 0);

    // Reset in DRAIN after row 0 has transferred.
    apply2(1, 5, 0, 1); @(negedge clk);
    apply2(0, 7, 6, 1); @(negedge clk);
    apply2(0, 0, 8, 1); @(negedge clk);
    expect2(1, 0, 5, 6, 0, 0, 0);
    @(negedge clk);
    expect2(1, 1, 7, 8, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    expect2(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("rst_hold_done", int'(done2), 0);
    rst_n = 1'b1;
    @(negedge clk);
    expect2(0, 0, 0, 0, 0, 1, 0);
    apply2(1, 9, 0, 1);   @(negedge clk);
    apply2(0, 11, 10, 1); @(negedge clk);
    apply2(0, 0, 12, 1);  @(negedge clk);
    expect2(1, 0, 9, 10, 0, 0, 0);
    @(negedge clk);
    expect2(1, 1, 11, 12, 0, 0, 0);
    @(negedge clk);
    expect2(0, 0, 0, 0, 1, 1, 0);

    // N=4: two back-to-back fixed tiles at full drain rate.
    exp_rows.delete();
    start_edges.delete();
    fork
      begin
        drive_tile4(1'b1);
        drive_tile4(1'b1);
      end
      monitor4(2, 1'b0);
    join
    if (start_edges.size() >= 2) chk("n4_b2b_gap", start_edges[1] - start_edges[0], 11);
    else begin
      checks++; errors++;
      $display("FAIL n4_b2b_gap: got %0d starts expected 2", start_edges.size());
    end

    // N=4: random tiles with random consumer backpressure.
    exp_rows.delete();
    start_edges.delete();
    fork
      begin
        for (int t = 0; t < 6; t++) drive_tile4(1'b0);
      end
      monitor4(6, 1'b1);
    join
    chk("n4_overrun_clear", int'(ovr4), 0);
    chk("n4_idle_at_end",   int'(ordy4), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
